// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding and default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_bit.sv
// One-bit subtractor cell: diff = x - y - bi.
// Subtract-direction counterpart of the full-adder cell.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = a - b - bin over WIDTH cycles.
// A single subtractor cell is reused each cycle with a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             dbit;
  logic             bnext;
  logic [WIDTH-1:0] res_next;

  full_subtractor_bit u_cell (
    .x    (opa[0]),
    .y    (opb[0]),
    .bi   (br),
    .diff (dbit),
    .bo   (bnext)
  );

  assign res_next = {dbit, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          opa <= opa >> 1;
          opb <= opb >> 1;
          res <= res_next;
          br  <= bnext;
          cnt <= cnt + 1'b1;
          // Final bit: publish result, borrow and overflow together
          if (cnt == CW'(WIDTH - 1)) begin
            d     <= res_next;
            bout  <= bnext;
            ovf   <= (a_msb != b_msb) && (dbit != a_msb);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Random and directed operations against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_d = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic bi, output logic [W-1:0] dd,
                                output logic bo, output logic ov);
    int ua, ub, sa, sb, r;
    ua = int'(x);
    ub = int'(y);
    bo = (ua < ub + int'(bi));
    dd = W'(ua - ub - int'(bi));
    sa = int'($signed(x));
    sb = int'($signed(y));
    r  = sa - sb - int'(bi);
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin);
    logic [W-1:0] ed;
    logic eb, eo;
    int n;
    model(ta, tb, tbin, ed, eb, eo);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("busy_acc", busy, 1);
    n = 0;
    while (!done && n < W + 4) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) chk("hold_d", d, prev_d);
    end
    chk("latency", n, W);
    chk("d", d, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    chk("busy_done", busy, 1);
    prev_d = ed;
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rbin;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin);
    end

    // Starts while busy are dropped; only the edge k+10 start is accepted
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 8 || e == 9 || e == 10);
      a = 8'h09; b = 8'h01; bin = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        seen++;
        if (e == 8) chk("b2b_first", d, 8'h02);
        else if (e == 18) chk("b2b_second", d, 8'h08);
        else chk("b2b_stray_done", e, 0);
      end
    end
    start = 1'b0;
    chk("b2b_count", seen, 2);
    prev_d = 8'h08;

    // Reset mid-SHIFT aborts the operation
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d", d, 0);
    chk("abort_bout", bout, 0);
    chk("abort_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = '0;
    seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(8'h05, 8'h03, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
